// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer slice.
package seq_pkg;

  localparam int unsigned WORD_W = 10;
  localparam int unsigned TS_W   = 2;

  typedef logic [TS_W-1:0] ts_t;

  localparam ts_t TS_FETCH = 2'b00;
  localparam ts_t TS_LAST  = 2'b11;

endpackage

// File: rtl/seq_fifo.sv
// Word FIFO feeding the external data path.
// Head word is read combinationally; there is no empty bypass, so a word
// written this cycle becomes visible at the head on the next cycle.
module seq_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WORD_W = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Combinational head read, zero while empty.
  always_comb begin
    rdata = '0;
    if (!empty) rdata = mem[rd_ptr];
  end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: owns the 2-bit timestep, stalls on a missing
// external word, pulses done after Clr, and buffers words in seq_fifo.
// Optional macro SEQ_INSTR_COUNT_EN enables the saturating instr_count.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WORD_W = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     in_valid,
  input  logic [WORD_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic                     Ext,
  input  logic                     Clr,
  output logic [WORD_W-1:0]        data_out,
  output logic [1:0]               timestep,
  output logic                     stall,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              instr_count
);

  ts_t  ts;
  ts_t  ts_next;
  logic done_next;
  logic active;
  logic advance;
  logic push;
  logic pop;
  logic full;
  logic empty;

  assign active   = run || (ts != TS_FETCH);
  assign stall    = active && Ext && empty;
  assign advance  = active && !stall;
  assign pop      = advance && Ext;
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign timestep = ts;

  seq_fifo #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .wdata  (in_data),
    .rdata  (data_out),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  // Timestep and completion-pulse state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts   <= TS_FETCH;
      done <= 1'b0;
    end else begin
      ts   <= ts_next;
      done <= done_next;
    end
  end

  // Next timestep: idle holds fetch, stall holds, Clr returns to fetch.
  // A Clr presented during a stall is deferred because advance is low.
  always_comb begin
    ts_next   = ts;
    done_next = 1'b0;
    if (!active) begin
      ts_next = TS_FETCH;
    end else if (advance) begin
      if (Clr) begin
        ts_next   = TS_FETCH;
        done_next = 1'b1;
      end else if (ts == TS_LAST) begin
        ts_next = TS_FETCH;
      end else begin
        ts_next = ts_t'(ts + 1'b1);
      end
    end
  end

`ifdef SEQ_INSTR_COUNT_EN
  logic [15:0] cnt;

  // Completed-instruction counter, saturating at all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (done && (cnt != '1)) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign instr_count = cnt;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer (DEPTH=4, WORD_W=10).
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       in_valid;
  logic [9:0] in_data;
  logic       in_ready;
  logic       Ext;
  logic       Clr;
  logic [9:0] data_out;
  logic [1:0] timestep;
  logic       stall;
  logic       done;
  logic [2:0] level;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  instr_sequencer #(
    .DEPTH  (4),
    .WORD_W (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .Ext         (Ext),
    .Clr         (Clr),
    .data_out    (data_out),
    .timestep    (timestep),
    .stall       (stall),
    .done        (done),
    .level       (level),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // One clock edge, then settle 1ns past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 0; in_valid = 0; in_data = '0; Ext = 0; Clr = 0;
    cyc();
    checks++; if (timestep !== 2'd0) begin errors++; $display("FAIL por_ts got %0d want 0", timestep); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL por_level got %0d want 0", level); end
    reset = 1'b0;
    cyc();
    // fill four words, fetch one, move to ts2
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = 10'(i + 16); cyc();
    end
    in_valid = 0;
    run = 1; Ext = 1; cyc();
    Ext = 0; cyc();
    checks++; if (timestep !== 2'd2) begin errors++; $display("FAIL pre_ts got %0d want 2", timestep); end
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL pre_level got %0d want 3", level); end
    #2 reset = 1'b1;
    #1;
    checks++; if (timestep !== 2'd0) begin errors++; $display("FAIL arst_ts got %0d want 0", timestep); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL arst_level got %0d want 0", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %0b want 1", in_ready); end
    checks++; if (data_out !== 10'h000) begin errors++; $display("FAIL arst_data got %h want 000", data_out); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done got %0b want 0", done); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL arst_stall got %0b want 0", stall); end
    checks++; if (instr_count !== 16'h0) begin errors++; $display("FAIL arst_cnt got %h want 0000", instr_count); end
    run = 0;
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_alu();
    logic [1:0] exp_ts [5];
    exp_ts[0] = 2'd0; exp_ts[1] = 2'd1; exp_ts[2] = 2'd2; exp_ts[3] = 2'd3; exp_ts[4] = 2'd0;
    in_valid = 1; in_data = 10'h048; cyc();
    in_valid = 0;
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL alu_lvl0 got %0d want 1", level); end
    checks++; if (data_out !== 10'h048) begin errors++; $display("FAIL alu_head got %h want 048", data_out); end
    run = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (timestep !== exp_ts[i]) begin errors++; $display("FAIL alu_ts%0d got %0d want %0d", i, timestep, exp_ts[i]); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL alu_done_early%0d got %0b want 0", i, done); end
      Ext = (i == 0); Clr = (i == 3);
      cyc();
      if (i == 0) begin
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL alu_lvl1 got %0d want 0", level); end
      end
    end
    run = 0; Ext = 0; Clr = 0;
    checks++; if (timestep !== exp_ts[4]) begin errors++; $display("FAIL alu_ts_end got %0d want 0", timestep); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL alu_done got %0b want 1", done); end
    cyc();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL alu_done_clear got %0b want 0", done); end
  endtask

  task automatic test_load();
    // idle with Ext on an empty FIFO is not a stall
    Ext = 1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_stall got %0b want 0", stall); end
    Ext = 0;
    in_valid = 1; in_data = 10'h000; cyc();
    in_valid = 0; in_data = 10'h155;
    run = 1; Ext = 1; cyc();
    run = 0; Clr = 1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_stall got %0b want 1", stall); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (timestep !== 2'd1) begin errors++; $display("FAIL load_hold%0d got %0d want 1", i, timestep); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_stall%0d got %0b want 1", i, stall); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL load_done%0d got %0b want 0", i, done); end
    end
    in_valid = 1; cyc();
    in_valid = 0;
    checks++; if (timestep !== 2'd1) begin errors++; $display("FAIL load_pushcyc_ts got %0d want 1", timestep); end
    checks++; if (data_out !== 10'h155) begin errors++; $display("FAIL load_data got %h want 155", data_out); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_unstall got %0b want 0", stall); end
    cyc();
    Ext = 0; Clr = 0;
    checks++; if (timestep !== 2'd0) begin errors++; $display("FAIL load_ts_end got %0d want 0", timestep); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL load_level got %0d want 0", level); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL load_done got %0b want 1", done); end
    cyc();
  endtask

  task automatic test_full();
    run = 0;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1; in_data = 10'(i);
      #1;
      checks++; if (in_ready !== (i <= 4)) begin errors++; $display("FAIL full_ready%0d got %0b want %0b", i, in_ready, (i <= 4)); end
      cyc();
    end
    in_valid = 0;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level got %0d want 4", level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready_end got %0b want 0", in_ready); end
    checks++; if (timestep !== 2'd0) begin errors++; $display("FAIL full_ts got %0d want 0", timestep); end
    checks++; if (data_out !== 10'h001) begin errors++; $display("FAIL full_head got %h want 001", data_out); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_seq [5];
    exp_seq[0] = 10'h001; exp_seq[1] = 10'h002; exp_seq[2] = 10'h003;
    exp_seq[3] = 10'h004; exp_seq[4] = 10'h0AA;
    run = 1; Ext = 1; Clr = 1;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2); in_data = 10'h0AA;
      #1;
      checks++; if (data_out !== exp_seq[i]) begin errors++; $display("FAIL b2b_data%0d got %h want %h", i, data_out, exp_seq[i]); end
      cyc();
      if (i == 2) begin
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL b2b_level got %0d want 2", level); end
      end
    end
    in_valid = 0; run = 0; Ext = 0; Clr = 0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL b2b_empty got %0d want 0", level); end
    checks++; if (data_out !== 10'h000) begin errors++; $display("FAIL b2b_data_empty got %h want 000", data_out); end
    checks++; if (timestep !== 2'd0) begin errors++; $display("FAIL b2b_ts got %0d want 0", timestep); end
    cyc();
  endtask

  task automatic test_count();
    logic [15:0] exp_cnt;
    reset = 1; #1; reset = 0;
    cyc();
    for (int n = 1; n <= 3; n++) begin
      in_valid = 1; in_data = 10'(n); cyc();
      in_valid = 0;
      run = 1; Ext = 1; Clr = 1; cyc();
      run = 0; Ext = 0; Clr = 0; cyc();
`ifdef SEQ_INSTR_COUNT_EN
      exp_cnt = 16'(n);
`else
      exp_cnt = 16'h0000;
`endif
      checks++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL cnt%0d got %h want %h", n, instr_count, exp_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_full();
    test_back_to_back();
    test_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
